// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback/display stage.
// Holds the opcode classes, the regfile-write predicate and the
// active-low seven-segment glyph table ({g,f,e,d,c,b,a}, 0 = lit).
package wb_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_ALU = 2'b01,
      OP_LD  = 2'b10,
      OP_ST  = 2'b11
   } op_e;

   // All segments off.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Hex glyphs, packed so that SEG_GLYPH[n] is the pattern for nibble n.
   // The list runs from F down to 0 because concatenation fills from the MSB.
   localparam logic [15:0][6:0] SEG_GLYPH = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   // Only ALU results and loads write the register file; stores and
   // bubbles pass through without a write.
   function automatic logic op_writes_rf(input logic [1:0] op);
      return (op == OP_ALU) || (op == OP_LD);
   endfunction

endpackage

// File: rtl/hex_seg7.sv
// hex_seg7: purely combinational nibble-to-segment decoder.
// Output is active-low {g,f,e,d,c,b,a}, taken from the wb_pkg glyph table.
module hex_seg7
   import wb_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup; every nibble value has a glyph, so no default is needed.
   assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/wb_disp_stage.sv
// wb_disp_stage: registered writeback stage at the end of the pipeline,
// plus a time-multiplexed hex display of the last committed value.
//
// Handshake: IN_VALID qualifies OP/DR/WB_DATA for one cycle. There is no
// ready; this stage accepts every cycle. Downstream qualifies WB_VAL and
// DR_OUT with WB_EN only (they are registered every cycle regardless).
//
// Optional build macro WB_DISP_LZB_EN: leading-zero blanking. When defined,
// digits above the most significant nonzero nibble of the held value are
// dark; digit 0 is never blanked. Scanning of DIG_SEL is unchanged.
module wb_disp_stage
   import wb_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int DR_W     = 3,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  IN_VALID,
   input  logic [1:0]            OP,
   input  logic [DR_W-1:0]       DR,
   input  logic [DATA_W-1:0]     WB_DATA,
   input  logic                  FREEZE,
   output logic [DATA_W-1:0]     WB_VAL,
   output logic                  WB_EN,
   output logic [DR_W-1:0]       DR_OUT,
   output logic [6:0]            SEG,
   output logic [DATA_W/4-1:0]   DIG_SEL
);

   localparam int NDIG   = DATA_W / 4;
   localparam int DIDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
   localparam logic [DIDX_W-1:0] DIDX_LAST = DIDX_W'(NDIG - 1);

   logic                commit;
   logic [DATA_W-1:0]   wb_val_q;
   logic                wb_en_q;
   logic [DR_W-1:0]     dr_q;
   logic [DATA_W-1:0]   disp_q;
   logic [PRE_W-1:0]    pre_q;
   logic [DIDX_W-1:0]   didx_q;
   logic [3:0]          nibble;
   logic [6:0]          glyph;
   logic [NDIG-1:0]     dig_sel;

   assign commit = IN_VALID && op_writes_rf(OP);

   // Writeback payload: data and destination are captured every cycle,
   // the enable only when the incoming op actually commits.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wb_val_q <= '0;
         wb_en_q  <= 1'b0;
         dr_q     <= '0;
      end else begin
         wb_val_q <= WB_DATA;
         wb_en_q  <= commit;
         dr_q     <= DR;
      end
   end

   // Display hold register: follows commits unless frozen for debug.
   // A commit coinciding with FREEZE going high is deliberately dropped.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         disp_q <= '0;
      end else if (commit && !FREEZE) begin
         disp_q <= WB_DATA;
      end
   end

   // Scan timing: prescaler wraps every SCAN_DIV cycles and steps the digit.
   // With SCAN_DIV == 1 the prescaler is stuck at its last value, so the
   // digit steps every cycle.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pre_q  <= '0;
         didx_q <= '0;
      end else if (pre_q == PRE_LAST) begin
         pre_q  <= '0;
         didx_q <= (didx_q == DIDX_LAST) ? '0 : didx_q + DIDX_W'(1);
      end else begin
         pre_q  <= pre_q + PRE_W'(1);
      end
   end

   // Nibble select for the current digit; a loop keeps the mux in range
   // even when NDIG is not a power of two.
   always_comb begin
      nibble = 4'h0;
      for (int i = 0; i < NDIG; i++) begin
         if (didx_q == DIDX_W'(i)) begin
            nibble = disp_q[4*i +: 4];
         end
      end
   end

   // Active-low one-hot digit enable derived from the registered index.
   always_comb begin
      dig_sel = '1;
      for (int i = 0; i < NDIG; i++) begin
         if (didx_q == DIDX_W'(i)) begin
            dig_sel[i] = 1'b0;
         end
      end
   end

   hex_seg7 u_hex_seg7 (
      .nibble (nibble),
      .seg    (glyph)
   );

`ifdef WB_DISP_LZB_EN
   logic [DIDX_W-1:0] msd;

   // Index of the most significant nonzero nibble; 0 when the value is zero,
   // which keeps digit 0 lit as a single "0".
   always_comb begin
      msd = '0;
      for (int i = 1; i < NDIG; i++) begin
         if (disp_q[4*i +: 4] != 4'h0) begin
            msd = DIDX_W'(i);
         end
      end
   end

   assign SEG = (didx_q > msd) ? SEG_BLANK : glyph;
`else
   assign SEG = glyph;
`endif

   assign WB_VAL  = wb_val_q;
   assign WB_EN   = wb_en_q;
   assign DR_OUT  = dr_q;
   assign DIG_SEL = dig_sel;

endmodule

// File: tb/tb_wb_disp_stage.sv
// tb_wb_disp_stage: directed bench for wb_disp_stage with SCAN_DIV = 2.
// Each digit stays lit for two cycles, so after k clock edges since reset
// release the selected digit is (k/2) mod 4.
module tb_wb_disp_stage;

   localparam int DATA_W   = 16;
   localparam int DR_W     = 3;
   localparam int SCAN_DIV = 2;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic [1:0]        op;
   logic [DR_W-1:0]   dr;
   logic [DATA_W-1:0] wb_data;
   logic              freeze;
   logic [DATA_W-1:0] wb_val;
   logic              wb_en;
   logic [DR_W-1:0]   dr_out;
   logic [6:0]        seg;
   logic [3:0]        dig_sel;

   logic [DATA_W-1:0] exp_q[$];
   int                n_checks;
   int                n_pass;
   int                k;

   wb_disp_stage #(
      .DATA_W   (DATA_W),
      .DR_W     (DR_W),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .IN_VALID (in_valid),
      .OP       (op),
      .DR       (dr),
      .WB_DATA  (wb_data),
      .FREEZE   (freeze),
      .WB_VAL   (wb_val),
      .WB_EN    (wb_en),
      .DR_OUT   (dr_out),
      .SEG      (seg),
      .DIG_SEL  (dig_sel)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Hand-written glyph table, active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph_of(input logic [3:0] n);
      case (n)
         4'h0: glyph_of = 7'b1000000;
         4'h1: glyph_of = 7'b1111001;
         4'h2: glyph_of = 7'b0100100;
         4'h3: glyph_of = 7'b0110000;
         4'h4: glyph_of = 7'b0011001;
         4'h5: glyph_of = 7'b0010010;
         4'h6: glyph_of = 7'b0000010;
         4'h7: glyph_of = 7'b1111000;
         4'h8: glyph_of = 7'b0000000;
         4'h9: glyph_of = 7'b0010000;
         4'hA: glyph_of = 7'b0001000;
         4'hB: glyph_of = 7'b0000011;
         4'hC: glyph_of = 7'b1000110;
         4'hD: glyph_of = 7'b0100001;
         4'hE: glyph_of = 7'b0000110;
         default: glyph_of = 7'b0001110;
      endcase
   endfunction

   // Display check for the digit that should be selected now.
   task automatic check_disp(input logic [15:0] d);
      int         didx;
      int         msd;
      logic [3:0] nib;
      logic [3:0] exp_sel;
      logic [6:0] exp_seg;
      didx    = (k / 2) % 4;
      nib     = d[4*didx +: 4];
      exp_sel = 4'b1111;
      exp_sel[didx] = 1'b0;
      exp_seg = glyph_of(nib);
`ifdef WB_DISP_LZB_EN
      msd = 0;
      for (int i = 1; i < 4; i++) begin
         if (d[4*i +: 4] != 4'h0) msd = i;
      end
      if (didx > msd) exp_seg = 7'b1111111;
`else
      msd = 0;
`endif
      check("dig_sel", {28'h0, dig_sel}, {28'h0, exp_sel});
      check("seg", {25'h0, seg}, {25'h0, exp_seg});
   endtask

   // One cycle with reset held low; all outputs must be at reset values.
   task automatic rst_cycle(input logic v, input logic [1:0] o, input logic [15:0] data);
      rst_n    = 1'b0;
      in_valid = v;
      op       = o;
      dr       = 3'd5;
      wb_data  = data;
      freeze   = 1'b0;
      @(posedge clk);
      k = 0;
      #1;
      check("rst_wb_val", {16'h0, wb_val}, 32'h0);
      check("rst_wb_en", {31'h0, wb_en}, 32'h0);
      check("rst_dr_out", {29'h0, dr_out}, 32'h0);
      check("rst_dig_sel", {28'h0, dig_sel}, 32'h0000_000E);
      check("rst_seg", {25'h0, seg}, 32'h0000_0040);
   endtask

   // One running cycle: drive, clock, then check the registered payload
   // and the display against the hand-supplied expectations.
   task automatic cycle(input logic v, input logic [1:0] o, input logic [2:0] d,
                        input logic [15:0] data, input logic frz,
                        input logic exp_en, input logic [15:0] exp_disp);
      in_valid = v;
      op       = o;
      dr       = d;
      wb_data  = data;
      freeze   = frz;
      exp_q.push_back(data);
      @(posedge clk);
      k++;
      #1;
      check("wb_val", {16'h0, wb_val}, {16'h0, exp_q.pop_front()});
      check("wb_en", {31'h0, wb_en}, {31'h0, exp_en});
      check("dr_out", {29'h0, dr_out}, {29'h0, d});
      check_disp(exp_disp);
   endtask

   task automatic idle(input int n, input logic [15:0] exp_disp);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 2'b01, 3'd0, 16'h0000, 1'b0, 1'b0, exp_disp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      k        = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      op       = 2'b00;
      dr       = '0;
      wb_data  = '0;
      freeze   = 1'b0;

      // Reset held three cycles while a commit of BEEF is offered.
      for (int i = 0; i < 3; i++) rst_cycle(1'b1, 2'b01, 16'hBEEF);
      rst_n = 1'b1;
      idle(1, 16'h0000);

      // Commit decode over all opcodes, then a non-valid ALU op.
      cycle(1'b1, 2'b00, 3'd1, 16'h1111, 1'b0, 1'b0, 16'h0000);
      cycle(1'b1, 2'b01, 3'd2, 16'h2222, 1'b0, 1'b1, 16'h2222);
      cycle(1'b1, 2'b10, 3'd3, 16'h3333, 1'b0, 1'b1, 16'h3333);
      cycle(1'b1, 2'b11, 3'd4, 16'h4444, 1'b0, 1'b0, 16'h3333);
      cycle(1'b0, 2'b01, 3'd5, 16'h5555, 1'b0, 1'b0, 16'h3333);

      // Scan: fresh reset (commit at the reset edge is discarded), then 12AF.
      rst_cycle(1'b1, 2'b01, 16'h9999);
      rst_n = 1'b1;
      cycle(1'b1, 2'b01, 3'd6, 16'h12AF, 1'b0, 1'b1, 16'h12AF);
      idle(10, 16'h12AF);
      // k is now 11 (prescaler at its last count): commit lands on the wrap.
      cycle(1'b1, 2'b10, 3'd7, 16'h3C4D, 1'b0, 1'b1, 16'h3C4D);
      idle(7, 16'h3C4D);

      // Freeze: 5555 arrives with FREEZE rising and must not be captured.
      cycle(1'b1, 2'b01, 3'd0, 16'h0001, 1'b0, 1'b1, 16'h0001);
      cycle(1'b1, 2'b10, 3'd1, 16'h5555, 1'b1, 1'b1, 16'h0001);
      for (int i = 0; i < 7; i++) cycle(1'b1, 2'b01, 3'd2, 16'h6666, 1'b1, 1'b1, 16'h0001);
      cycle(1'b1, 2'b01, 3'd3, 16'h7777, 1'b0, 1'b1, 16'h7777);
      idle(7, 16'h7777);

      // Leading zeros (blanked only when the macro is defined).
      cycle(1'b1, 2'b01, 3'd4, 16'h00A0, 1'b0, 1'b1, 16'h00A0);
      idle(7, 16'h00A0);
      cycle(1'b1, 2'b10, 3'd5, 16'h0000, 1'b0, 1'b1, 16'h0000);
      idle(7, 16'h0000);

      // Mid-scan reset with FFFF held and the scan parked on digit 2.
      cycle(1'b1, 2'b01, 3'd6, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF);
      for (int i = 0; i < 8 && ((k / 2) % 4) != 2; i++) idle(1, 16'hFFFF);
      check("mid_didx2", {28'h0, dig_sel}, 32'h0000_000B);
      rst_cycle(1'b1, 2'b01, 16'h1234);
      rst_n = 1'b1;
      // Prescaler restarted: digit 0 for two cycles, then digit 1.
      idle(4, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
